// File: rtl/haz_pkg.sv
// Shared types for the decode-stage hazard unit: forward encodings,
// shadow-pipeline tag struct and the producer tag-match helper.
package haz_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic       RegWrite;
        logic       MemtoReg;
        logic [4:0] WriteReg;
    } haz_tag_t;

    // Register 0 is hard-wired, so it never participates in a hazard.
    function automatic logic tag_match(input logic [4:0] idx, input haz_tag_t t);
        return (idx != REG_ZERO) && t.RegWrite && (idx == t.WriteReg);
    endfunction

endpackage

// File: rtl/haz_tag_pipe.sv
// E/M/W shadow pipeline of destination tags; E becomes a bubble on flush.
module haz_tag_pipe
    import haz_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush_i,
    input  haz_tag_t tag_d_i,
    input  logic [4:0] rs_d_i,
    input  logic [4:0] rt_d_i,
    output haz_tag_t tag_e_o,
    output haz_tag_t tag_m_o,
    output haz_tag_t tag_w_o,
    output logic [4:0] rs_e_o,
    output logic [4:0] rt_e_o
);

    haz_tag_t   tag_e_q, tag_m_q, tag_w_q;
    logic [4:0] rs_e_q, rt_e_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_e_q <= '0;
            tag_m_q <= '0;
            tag_w_q <= '0;
            rs_e_q  <= '0;
            rt_e_q  <= '0;
        end else begin
            if (flush_i) begin
                tag_e_q <= '0;
                rs_e_q  <= '0;
                rt_e_q  <= '0;
            end else begin
                tag_e_q <= tag_d_i;
                rs_e_q  <= rs_d_i;
                rt_e_q  <= rt_d_i;
            end
            tag_m_q <= tag_e_q;
            tag_w_q <= tag_m_q;
        end
    end

    assign tag_e_o = tag_e_q;
    assign tag_m_o = tag_m_q;
    assign tag_w_o = tag_w_q;
    assign rs_e_o  = rs_e_q;
    assign rt_e_o  = rt_e_q;

endmodule

// File: rtl/hazard_unit.sv
// Decode-stage hazard/forwarding controller with saturating stall counter.
// Define EX_FWD_EN to enable execute-stage forwarding (else stall on any E/M match).
module hazard_unit
    import haz_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic        UseRsD,
    input  logic        UseRtD,
    input  logic [4:0]  WriteRegD,
    input  logic        RegWriteD,
    input  logic        MemtoRegD,
    input  logic        BranchD,
    input  logic        ClrCnt,
    output logic        ForwardAD,
    output logic        ForwardBD,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushE,
    output logic [31:0] StallCnt
);

    haz_tag_t   tag_d, tag_e, tag_m, tag_w;
    logic [4:0] rs_e, rt_e;
    logic       use_e, use_m, lwstall, branchstall, stall;
    fwd_sel_e   fwd_a, fwd_b;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic       unused_tags;

    assign tag_d = '{RegWrite: RegWriteD, MemtoReg: MemtoRegD, WriteReg: WriteRegD};

    haz_tag_pipe u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (stall),
        .tag_d_i (tag_d),
        .rs_d_i  (RsD),
        .rt_d_i  (RtD),
        .tag_e_o (tag_e),
        .tag_m_o (tag_m),
        .tag_w_o (tag_w),
        .rs_e_o  (rs_e),
        .rt_e_o  (rt_e)
    );

    always_comb begin
        use_e = (UseRsD && tag_match(RsD, tag_e)) || (UseRtD && tag_match(RtD, tag_e));
        use_m = (UseRsD && tag_match(RsD, tag_m)) || (UseRtD && tag_match(RtD, tag_m));
        lwstall     = tag_e.MemtoReg && use_e;
        branchstall = BranchD && (use_e || (tag_m.MemtoReg && use_m));
        stall       = lwstall || branchstall;
        fwd_a       = FWD_RF;
        fwd_b       = FWD_RF;
`ifdef EX_FWD_EN
        if (tag_match(rs_e, tag_m))      fwd_a = FWD_MEM;
        else if (tag_match(rs_e, tag_w)) fwd_a = FWD_WB;
        if (tag_match(rt_e, tag_m))      fwd_b = FWD_MEM;
        else if (tag_match(rt_e, tag_w)) fwd_b = FWD_WB;
`else
        // Without execute forwarding every in-flight producer must drain first.
        stall = stall || use_e || use_m;
`endif
    end

`ifdef EX_FWD_EN
    assign unused_tags = tag_w.MemtoReg;
`else
    assign unused_tags = ^{tag_w, rs_e, rt_e};
`endif

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (ClrCnt)
            stall_cnt_d = '0;
        else if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign ForwardAD = UseRsD && tag_match(RsD, tag_m);
    assign ForwardBD = UseRtD && tag_match(RtD, tag_m);
    assign ForwardAE = fwd_a;
    assign ForwardBE = fwd_b;
    assign StallF    = stall;
    assign StallD    = stall;
    assign FlushE    = stall;
    assign StallCnt  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed test-plan sequences plus random traffic
// checked against an instruction-history reference model.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  RsD, RtD, WriteRegD;
    logic        UseRsD, UseRtD, RegWriteD, MemtoRegD, BranchD, ClrCnt;
    logic        ForwardAD, ForwardBD, StallF, StallD, FlushE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] StallCnt;

    hazard_unit dut (
        .clk(clk), .rst_n(rst_n),
        .RsD(RsD), .RtD(RtD), .UseRsD(UseRsD), .UseRtD(UseRtD),
        .WriteRegD(WriteRegD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD),
        .BranchD(BranchD), .ClrCnt(ClrCnt),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .StallCnt(StallCnt)
    );

    always #5 clk = ~clk;

    // One in-flight instruction as seen by the model.
    typedef struct {
        bit rw;
        bit mtr;
        int wr;
        int rs;
        int rt;
    } instr_t;

    instr_t   st_e, st_m, st_w;
    longint   cnt_m;
    int       tests = 0;
    int       fails = 0;

    function automatic bit writes(int idx, instr_t p);
        return idx != 0 && p.rw && idx == p.wr;
    endfunction

    function automatic int ex_sel(int idx);
`ifdef EX_FWD_EN
        if (writes(idx, st_m)) return 2;
        if (writes(idx, st_w)) return 1;
`endif
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        st_e = '{0, 0, 0, 0, 0};
        st_m = st_e;
        st_w = st_e;
        cnt_m = 0;
    endtask

    task automatic step(input int rs, input int rt, input bit urs, input bit urt,
                        input int wr, input bit rw, input bit mtr, input bit br, input bit clr);
        bit in_e, in_m, exp_stall;
        RsD = 5'(rs); RtD = 5'(rt); UseRsD = urs; UseRtD = urt;
        WriteRegD = 5'(wr); RegWriteD = rw; MemtoRegD = mtr; BranchD = br; ClrCnt = clr;
        #1;
        in_e = (urs && writes(rs, st_e)) || (urt && writes(rt, st_e));
        in_m = (urs && writes(rs, st_m)) || (urt && writes(rt, st_m));
        exp_stall = (st_e.mtr && in_e) || (br && (in_e || (st_m.mtr && in_m)));
`ifndef EX_FWD_EN
        exp_stall = exp_stall || in_e || in_m;
`endif
        chk("ForwardAD", {31'd0, ForwardAD}, {31'd0, urs && writes(rs, st_m)});
        chk("ForwardBD", {31'd0, ForwardBD}, {31'd0, urt && writes(rt, st_m)});
        chk("ForwardAE", {30'd0, ForwardAE}, 32'(ex_sel(st_e.rs)));
        chk("ForwardBE", {30'd0, ForwardBE}, 32'(ex_sel(st_e.rt)));
        chk("StallF",    {31'd0, StallF},    {31'd0, exp_stall});
        chk("StallD",    {31'd0, StallD},    {31'd0, exp_stall});
        chk("FlushE",    {31'd0, FlushE},    {31'd0, exp_stall});
        chk("StallCnt",  StallCnt,           32'(cnt_m));
        @(posedge clk);
        st_w = st_m;
        st_m = st_e;
        if (exp_stall) st_e = '{0, 0, 0, 0, 0};
        else           st_e = '{rw, mtr, wr, rs, rt};
        if (clr)                                   cnt_m = 0;
        else if (exp_stall && cnt_m < 64'hFFFF_FFFF) cnt_m = cnt_m + 1;
        @(negedge clk);
    endtask

    task automatic nop();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_fwd"},   {28'd0, ForwardAD, ForwardBD, ForwardAE, ForwardBE}, 32'd0);
        chk({tag, "_stall"}, {29'd0, StallF, StallD, FlushE}, 32'd0);
        chk({tag, "_cnt"},   StallCnt, 32'd0);
    endtask

    initial begin
        model_reset();
        // Reset held with a hazard-looking decode and producers clocked in.
        rst_n = 1'b0;
        RsD = 5'd5; RtD = 5'd5; UseRsD = 1'b1; UseRtD = 1'b1;
        WriteRegD = 5'd5; RegWriteD = 1'b1; MemtoRegD = 1'b1; BranchD = 1'b1; ClrCnt = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // ALU result feeding a branch.
        step(1, 2, 1, 1, 3, 1, 0, 0, 0);
        step(3, 0, 1, 0, 0, 0, 0, 1, 0);
        step(3, 0, 1, 0, 0, 0, 0, 1, 0);
        nop(); nop();

        // Load feeding a branch.
        step(1, 0, 1, 0, 4, 1, 1, 0, 0);
        repeat (3) step(4, 0, 1, 0, 0, 0, 0, 1, 0);
        nop(); nop();

        // Load-use.
        step(2, 0, 1, 0, 8, 1, 1, 0, 0);
        repeat (2) step(8, 1, 1, 1, 10, 1, 0, 0, 0);
        nop(); nop();

        // M over W priority on $9, then $0 producers.
        step(1, 2, 1, 1, 9, 1, 0, 0, 0);
        step(1, 2, 1, 1, 9, 1, 0, 0, 0);
        step(9, 9, 1, 1, 11, 1, 0, 0, 0);
        nop();
        step(1, 1, 1, 1, 0, 1, 1, 0, 0);
        step(0, 0, 1, 1, 0, 1, 0, 1, 0);
        nop(); nop(); nop();

        // Saturation: preload counter, then stall twice.
        step(2, 0, 1, 0, 8, 1, 1, 0, 0);
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        cnt_m = 64'hFFFF_FFFF;
        step(8, 0, 1, 0, 12, 1, 0, 0, 0);
        step(1, 0, 1, 0, 13, 1, 1, 0, 0);
        step(13, 0, 1, 0, 0, 0, 0, 1, 0);
        chk("sat_hold", StallCnt, 32'hFFFF_FFFF);
        nop(); nop();

        // Clear wins over a simultaneous stall.
        step(2, 0, 1, 0, 8, 1, 1, 0, 0);
        step(8, 0, 1, 0, 12, 1, 0, 0, 1);
        chk("clr_prio", StallCnt, 32'd0);
        nop(); nop();

        // Random traffic on a small register set to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                rst_n = 1'b0;
                #1;
                check_all_zero("midreset");
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
            step($urandom_range(0, 3), $urandom_range(0, 3),
                 1'($urandom), 1'($urandom), $urandom_range(0, 3),
                 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
